alu_exec_stage: RTL
===================

Name: alu_exec_stage

Overview:
Registered execute stage that drives the ALU shifter and the other ALU datapaths. It accepts one operation per cycle from the decode stage over a valid/ready handshake and computes ADD/SUB/logic/shift/compare results. Results are returned downstream, with a tag, over a second valid/ready handshake. A 1-entry skid buffer keeps in_ready registered, so no combinational ready path crosses the stage.

Parameters:
TAG_W, 4, width of the opaque tag carried alongside each operation
RESET_TAG, 0, value loaded into the output tag register on reset

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operation offered by upstream
in_ready  out  1  stage can accept an operation; driven directly from a flop
in_op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10-15 illegal
in_a  in  32  operand x / shifted value
in_b  in  32  operand y / shift amount (full 32 bits significant)
in_tag  in  TAG_W  carried unchanged to the output
out_valid  out  1  result available
out_ready  in  1  downstream accepts the result
out_result  out  32  result
out_tag  out  TAG_W  tag of the result
out_illegal  out  1  opcode was 10-15

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - in_ready=1, out_valid=0, out_result=0, out_tag=RESET_TAG, out_illegal=0, skid empty.
  - Reset mid-operation discards the skid and output contents; no partial result is ever presented.
- Accept: in_valid & in_ready at a clock edge.
- Latency: 1 cycle. An operation accepted at edge N, with the output register free or draining, gives out_valid=1 with its result after edge N.
- Output register loads when (!out_valid | out_ready).
  - Load source: skid entry if the skid is full, otherwise the accepted input.
- Skid entry is filled only when an input is accepted while out_valid=1 and out_ready=0.
- in_ready(next) = !skid_full(next).
  - Skid full: in_ready=0 on the following cycle; in_valid is ignored while in_ready=0.
  - Skid drains into the output register on the first edge with out_ready=1; in_ready returns to 1 on the next cycle.
- Simultaneous events:
  - Output drain plus new accept with skid empty: the new op goes straight to the output register (back-to-back throughput of 1/cycle).
  - Skid drain and a new accept in the same cycle is impossible, because in_ready=0 while the skid is full.
- Ordering: strict FIFO; results never reorder or duplicate.
- While out_valid=1 and out_ready=0: out_result, out_tag and out_illegal hold stable.
- Arithmetic, all modulo 2^32:
  - ADD: a+b.
  - SUB: a-b.
  - AND / OR / XOR: bitwise.
  - SLT: 1 if signed a < signed b, else 0.
  - SLTU: 1 if unsigned a < unsigned b, else 0.
- Shifts use all 32 bits of b, matching the ALU shifter contract:
  - If b >= 32: SLL and SRL give 0; SRA gives 32 copies of a[31].
  - Otherwise: shift by b[4:0]; SRA fills with a[31].
  - b=0 returns a unchanged.
- Illegal opcode: out_result=0, out_illegal=1, and the operation still consumes a slot and returns its tag.
- Compute is done on the operation before it is registered, so the skid buffer and output register hold finished results. There is no combinational path from in_* to out_*, and none from out_ready to in_ready.

Optional Feature:
- Macro: ALU_EXEC_FLAGS_EN.
- When defined, adds output out_flags[3:0] = {N, Z, C, V}, registered with out_result and held under stall:
  - N = result[31]; Z = (result==0).
  - C = carry out for ADD, NOT borrow for SUB, else 0.
  - V = signed overflow for ADD/SUB, else 0.
  - Reset value 4'b0000.
- When undefined, the port and its logic are absent.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, in_ready=1, out_tag=RESET_TAG, no result emitted after release.
- Back-to-back with out_ready=1: ADD 5+7 tag 1, SUB 3-5 tag 2, SRA 0x80000000 by 4 tag 3 -> 0x0000000C, 0xFFFFFFFE, 0xF8000000 on consecutive cycles starting 1 cycle after the first accept.
- Shift saturation: SRL 0xFFFFFFFF by 0x00000020 -> 0; SRA 0x80000001 by 0x00010003 -> 0xFFFFFFFF; SLL 0x1 by 31 -> 0x80000000.
- Backpressure: out_ready=0, offer 3 ops -> 2 accepted, in_ready=0 the cycle after the 2nd, outputs stable; raise out_ready -> results in order, 3rd op accepted after in_ready returns.
- Compare and illegal: SLT 0xFFFFFFFF<1 -> 1; SLTU 0xFFFFFFFF<1 -> 0; opcode 12 -> result 0, out_illegal=1, tag preserved.
- Reset mid-stall: skid full, assert rst_n=0 for 1 cycle -> all state cleared, pending ops never appear on the output.

Source files
------------

// File: rtl/alu_exec_stage_if.sv
// Handshake bundle for alu_exec_stage: upstream op channel plus downstream
// result channel. With ALU_EXEC_FLAGS_EN defined, out_flags {N,Z,C,V} is added.
interface alu_exec_stage_if #(
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
`ifdef ALU_EXEC_FLAGS_EN
  logic [3:0]       out_flags;
`endif

`ifdef ALU_EXEC_FLAGS_EN
  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_illegal, out_flags
  );
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_illegal, out_flags
  );
`else
  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_illegal
  );
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_illegal
  );
`endif
endinterface

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered ALU execute stage with a 1-entry skid buffer.
// Results are computed before registering, so the skid entry and the output
// register always hold finished results. in_ready comes straight from a flop.
// Optional feature macro: ALU_EXEC_FLAGS_EN adds out_flags = {N, Z, C, V}.
module alu_exec_stage #(
  parameter int unsigned      TAG_W     = 4,
  parameter logic [TAG_W-1:0] RESET_TAG = '0
) (
  input logic             clk,
  input logic             rst_n,
  alu_exec_stage_if.slave alu
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } op_e;

  typedef enum logic {
    SKID_EMPTY = 1'b0,
    SKID_FULL  = 1'b1
  } skid_e;

  typedef struct packed {
`ifdef ALU_EXEC_FLAGS_EN
    logic [3:0]       flags;
`endif
    logic             illegal;
    logic [TAG_W-1:0] tag;
    logic [31:0]      result;
  } payload_t;

`ifdef ALU_EXEC_FLAGS_EN
  localparam int unsigned SUM_W = 33;
`else
  localparam int unsigned SUM_W = 32;
`endif

  // ---------------------------------------------------------------------------
  // Compute on the incoming operation
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_diff;
  logic             w_big_shamt;
  logic [31:0]      w_sra;
  logic [31:0]      w_res;
  logic             w_ill;
  payload_t         w_new;
  payload_t         w_reset_payload;

  // SUB is formed as a + ~b + 1 so the top bit doubles as the not-borrow flag
  assign w_sum       = SUM_W'(alu.in_a) + SUM_W'(alu.in_b);
  assign w_diff      = SUM_W'(alu.in_a) + SUM_W'(~alu.in_b) + SUM_W'(1);
  assign w_big_shamt = |alu.in_b[31:5];
  assign w_sra       = $signed(alu.in_a) >>> alu.in_b[4:0];

  // Result select; shift amounts of 32 or more saturate
  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    case (op_e'(alu.in_op))
      OP_ADD:  w_res = w_sum[31:0];
      OP_SUB:  w_res = w_diff[31:0];
      OP_AND:  w_res = alu.in_a & alu.in_b;
      OP_OR:   w_res = alu.in_a | alu.in_b;
      OP_XOR:  w_res = alu.in_a ^ alu.in_b;
      OP_SLL:  w_res = w_big_shamt ? '0 : (alu.in_a << alu.in_b[4:0]);
      OP_SRL:  w_res = w_big_shamt ? '0 : (alu.in_a >> alu.in_b[4:0]);
      OP_SRA:  w_res = w_big_shamt ? {32{alu.in_a[31]}} : w_sra;
      OP_SLT:  w_res = {31'd0, ($signed(alu.in_a) < $signed(alu.in_b))};
      OP_SLTU: w_res = {31'd0, (alu.in_a < alu.in_b)};
      default: w_ill = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_FLAGS_EN
  logic       w_c;
  logic       w_v;
  logic [3:0] w_flags;

  // Carry / overflow only meaningful for ADD and SUB
  always_comb begin
    w_c = 1'b0;
    w_v = 1'b0;
    case (op_e'(alu.in_op))
      OP_ADD: begin
        w_c = w_sum[32];
        w_v = (alu.in_a[31] == alu.in_b[31]) && (w_sum[31] != alu.in_a[31]);
      end
      OP_SUB: begin
        w_c = w_diff[32];
        w_v = (alu.in_a[31] != alu.in_b[31]) && (w_diff[31] != alu.in_a[31]);
      end
      default: ;
    endcase
  end

  assign w_flags = {w_res[31], (w_res == '0), w_c, w_v};
`endif

  // Pack the finished result for the skid / output registers
  always_comb begin
    w_new         = '0;
    w_new.result  = w_res;
    w_new.tag     = alu.in_tag;
    w_new.illegal = w_ill;
`ifdef ALU_EXEC_FLAGS_EN
    w_new.flags   = w_flags;
`endif
  end

  // Output register contents after reset
  always_comb begin
    w_reset_payload     = '0;
    w_reset_payload.tag = RESET_TAG;
  end

  // ---------------------------------------------------------------------------
  // Handshake and storage
  // ---------------------------------------------------------------------------
  skid_e    r_skid_state;
  skid_e    w_skid_next;
  payload_t r_skid;
  payload_t r_out;
  logic     r_out_valid;
  logic     r_in_ready;
  logic     w_accept;
  logic     w_out_load;

  assign w_accept   = alu.in_valid & r_in_ready;
  assign w_out_load = ~r_out_valid | alu.out_ready;

  // Skid occupancy register
  always_ff @(posedge clk) begin
    if (!rst_n) r_skid_state <= SKID_EMPTY;
    else        r_skid_state <= w_skid_next;
  end

  // Skid fills on an accept into a stalled output, empties on the next load
  always_comb begin
    w_skid_next = r_skid_state;
    case (r_skid_state)
      SKID_EMPTY: if (w_accept && !w_out_load) w_skid_next = SKID_FULL;
      SKID_FULL:  if (w_out_load)              w_skid_next = SKID_EMPTY;
    endcase
  end

  // in_ready registered from next skid occupancy, keeping out_ready off the path
  always_ff @(posedge clk) begin
    if (!rst_n) r_in_ready <= 1'b1;
    else        r_in_ready <= (w_skid_next == SKID_EMPTY);
  end

  // Skid data captures an accepted result that cannot enter the output register
  always_ff @(posedge clk) begin
    if (!rst_n)                       r_skid <= '0;
    else if (w_accept && !w_out_load) r_skid <= w_new;
  end

  // Output register: skid entry has priority to preserve FIFO order
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= w_reset_payload;
    end else if (w_out_load) begin
      if (r_skid_state == SKID_FULL) begin
        r_out_valid <= 1'b1;
        r_out       <= r_skid;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out       <= w_new;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign alu.in_ready    = r_in_ready;
  assign alu.out_valid   = r_out_valid;
  assign alu.out_result  = r_out.result;
  assign alu.out_tag     = r_out.tag;
  assign alu.out_illegal = r_out.illegal;
`ifdef ALU_EXEC_FLAGS_EN
  assign alu.out_flags   = r_out.flags;
`endif

endmodule
